inst_mem_pipe: RTL
==================

INST_MEM_PIPE -- requirements
Module: inst_mem_pipe

Interface
REQ-001 The block SHALL have parameter NUM_INST, default 256, meaning the instruction word depth (2 to 65536).
REQ-002 The block SHALL have parameter LATENCY, default 1, meaning the fetch pipeline depth in cycles (1 to 4).
REQ-003 The block SHALL have parameter NOP_WORD, default 32'h0000_0013, meaning the word returned on a faulting fetch.
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  fetch request present.
REQ-007 req_pc  in  32  byte address of the fetch.
REQ-008 req_ready  out  1  fetch request accepted this cycle when high together with req_valid.
REQ-009 flush  in  1  discard all in-flight fetches.
REQ-010 rsp_valid  out  1  response present.
REQ-011 rsp_ready  in  1  consumer accepts the response.
REQ-012 rsp_pc  out  32  req_pc of the returned fetch.
REQ-013 rsp_instruction  out  32  fetched word.
REQ-014 rsp_fault  out  2  bit0 = misaligned, bit1 = out of range.
REQ-015 load_en  in  1  program-load write strobe.
REQ-016 load_addr  in  clog2(NUM_INST)  word index of the load write.
REQ-017 load_data  in  32  word to write.
REQ-018 load_err  out  1  registered one-cycle pulse: the last load_en write was out of range.

Function
REQ-019 Storage SHALL be NUM_INST x 32-bit words, indexed by req_pc[31:2].
- No reset of contents.
- Written only through the load port.
REQ-020 A load write SHALL occur on a cycle with load_en=1 and load_addr < NUM_INST.
- load_addr >= NUM_INST: no write; load_err=1 in the following cycle.
REQ-021 The pipeline SHALL advance (adv) when stage LATENCY-1 is empty, or rsp_ready=1.
REQ-022 req_ready SHALL equal adv AND NOT load_en AND NOT flush.
REQ-023 Acceptance SHALL read storage in the accept cycle, capturing the word, PC and fault bits into stage 0.
- A later load write to that index does not alter the captured word.
REQ-024 Fault rules:
- req_pc[1:0] != 0 sets bit0.
- req_pc[31:2] >= NUM_INST sets bit1.
- Either bit set: rsp_instruction = NOP_WORD; no storage read is used.
REQ-025 Timing with no stall: request accepted at cycle t -> rsp_valid=1 with its data during cycle t+LATENCY.
REQ-026 Throughput SHALL be one fetch per cycle with no bubbles while rsp_ready=1.
REQ-027 When adv=0, every stage SHALL hold its contents.
- rsp_valid and all rsp_* outputs stay stable until rsp_ready=1.
REQ-028 Responses SHALL be returned in acceptance order, none dropped or duplicated except by flush or reset.
REQ-029 flush=1 SHALL clear all stage valid bits at the clock edge.
- rsp_valid=0 the next cycle.
- No request is accepted in a flush cycle.
- Flush overrides a simultaneous rsp_ready handshake for all other stages.
REQ-030 load_en=1 with req_valid=1 in the same cycle: the load write wins and the request is not accepted (req_ready=0).
REQ-031 The request interface SHALL be valid/ready.
- req_pc need only be stable while req_valid=1 and req_ready=0.
- Holding req_valid low never creates a response.

Reset
REQ-032 When rst=1 at a rising edge, the block SHALL clear all stage valid bits.
- rsp_valid=0, rsp_pc=0, rsp_instruction=0, rsp_fault=0, load_err=0 from the next cycle.
REQ-033 req_ready SHALL be 0 during any cycle with rst=1; storage contents are unaffected by reset.
REQ-034 rst asserted mid-operation SHALL discard all in-flight fetches.
- No response for them is ever produced.
- A load write in the same cycle as rst is still performed.

Verification
REQ-035 Load then fetch, LATENCY=1, rsp_ready=1:
- Stimulus: load word 2 = 0x00C28293; fetch pc=8.
- Response: rsp_valid the next cycle, rsp_instruction=0x00C28293, rsp_pc=8, rsp_fault=0.
REQ-036 Back-to-back, LATENCY=3:
- Stimulus: fetch pc=0,4,8,12 in consecutive cycles.
- Response: four consecutive responses in order, the first 3 cycles after the first accept.
REQ-037 Stall:
- Stimulus: rsp_ready=0 for 5 cycles with a full pipeline.
- Response: outputs frozen, req_ready=0; on rsp_ready=1 the remaining responses drain in order with none lost.
REQ-038 Faults, NUM_INST=256:
- pc=0x6 -> rsp_fault=01, rsp_instruction=0x00000013.
- pc=0x400 -> rsp_fault=10, rsp_instruction=0x00000013.
- pc=0x402 -> rsp_fault=11, rsp_instruction=0x00000013.
REQ-039 Flush and reset mid-stream, LATENCY=2:
- Stimulus: flush the cycle after 2 accepts.
- Response: no response for those fetches; a fetch accepted after the flush returns normally.
- The same sequence with rst in place of flush gives the same result.
REQ-040 Load/fetch collision:
- Stimulus: load_en and req_valid both high in one cycle.
- Response: req_ready=0 and the write is performed.
- A load to load_addr >= NUM_INST (NUM_INST=200, addr 250) -> load_err pulse, storage unchanged.

Source files
------------

// File: rtl/inst_mem_pipe_if.sv
// Fetch request/response bundle between an instruction fetch unit and inst_mem_pipe.
interface inst_mem_pipe_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_pc;
  logic [31:0] rsp_instruction;
  logic [1:0]  rsp_fault;

  modport master (
    output req_valid, req_pc, rsp_ready,
    input  req_ready, rsp_valid, rsp_pc, rsp_instruction, rsp_fault
  );

  modport slave (
    input  req_valid, req_pc, rsp_ready,
    output req_ready, rsp_valid, rsp_pc, rsp_instruction, rsp_fault
  );
endinterface

// File: rtl/inst_mem_pipe.sv
// Instruction memory with a loadable word store and a fixed-depth, stallable fetch pipeline.
module inst_mem_pipe #(
  parameter int          NUM_INST = 256,
  parameter int          LATENCY  = 1,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic                        clk,
  input  logic                        rst,
  inst_mem_pipe_if.slave              fetch,
  input  logic                        flush,
  input  logic                        load_en,
  input  logic [$clog2(NUM_INST)-1:0] load_addr,
  input  logic [31:0]                 load_data,
  output logic                        load_err
);
  localparam int          AW         = $clog2(NUM_INST);
  localparam int          AWP        = AW + 1;
  localparam logic [AW:0] LOAD_LIMIT = AWP'(NUM_INST);
  localparam logic [29:0] WORD_LIMIT = 30'(NUM_INST);

  logic [31:0]        mem [NUM_INST];
  logic [LATENCY-1:0] v_q;
  logic [31:0]        pc_q  [LATENCY];
  logic [31:0]        ins_q [LATENCY];
  logic [1:0]         flt_q [LATENCY];

  logic        adv;
  logic        accept;
  logic        load_ok;
  logic [1:0]  fault_in;
  logic [31:0] word_in;

  assign load_ok         = {1'b0, load_addr} < LOAD_LIMIT;
  assign adv             = !v_q[LATENCY-1] || fetch.rsp_ready;
  assign fetch.req_ready = adv && !load_en && !flush && !rst;
  assign accept          = fetch.req_valid && fetch.req_ready;

  assign fault_in = {fetch.req_pc[31:2] >= WORD_LIMIT, fetch.req_pc[1:0] != 2'b00};
  // A faulting fetch never touches storage; the word index may be past the array.
  assign word_in  = (fault_in != 2'b00) ? NOP_WORD : mem[fetch.req_pc[AW+1:2]];

  // Storage is not reset so a program loaded before a reset survives it.
  always_ff @(posedge clk) begin
    if (load_en && load_ok) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q      <= '0;
      load_err <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        pc_q[i]  <= '0;
        ins_q[i] <= '0;
        flt_q[i] <= '0;
      end
    end else begin
      load_err <= load_en && !load_ok;
      if (flush) begin
        v_q <= '0;
      end else if (adv) begin
        v_q[0] <= accept;
        for (int i = 1; i < LATENCY; i++) begin
          v_q[i] <= v_q[i-1];
        end
      end
      // Payload moves with the whole pipe; valid bits alone decide what is live.
      if (adv) begin
        if (accept) begin
          pc_q[0]  <= fetch.req_pc;
          ins_q[0] <= word_in;
          flt_q[0] <= fault_in;
        end
        for (int i = 1; i < LATENCY; i++) begin
          pc_q[i]  <= pc_q[i-1];
          ins_q[i] <= ins_q[i-1];
          flt_q[i] <= flt_q[i-1];
        end
      end
    end
  end

  assign fetch.rsp_valid       = v_q[LATENCY-1];
  assign fetch.rsp_pc          = pc_q[LATENCY-1];
  assign fetch.rsp_instruction = ins_q[LATENCY-1];
  assign fetch.rsp_fault       = flt_q[LATENCY-1];
endmodule
